// File: rtl/icebus_motor_bank.sv
// rtl/icebus_motor_bank.sv - per-motor register bank with iCE motor board byte-stream engine
//
// Purpose: Avalon-MM slave exposing per-motor PID/limit/setpoint registers and
// read-only telemetry. A TX engine streams periodic 8-byte command frames
// round-robin over all motors. An RX engine parses 17-byte status frames into
// the telemetry registers.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   address[15:0]         [15:8] motor index (0xFF = global), [7:0] register
//   write, writedata      zero-wait-state register write
//   read, readdata        one-wait-state register read
//   waitrequest           high during the first cycle of a read
//   tx_data, tx_valid     outgoing byte toward the UART, held until tx_ready
//   tx_ready              UART accepts the current byte
//   rx_data, rx_valid     incoming byte, one-cycle strobe

module icebus_motor_bank #(
  parameter int NUM_MOTORS           = 6,
  parameter int UPDATE_PERIOD_CYCLES = 50000,
  parameter int RX_TIMEOUT_CYCLES    = 5000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int          MIW         = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
  localparam logic [8:0]  NM          = 9'(NUM_MOTORS);
  localparam logic [7:0]  LAST_MOTOR  = 8'(NUM_MOTORS - 1);
  localparam logic [31:0] PERIOD_LAST = 32'(UPDATE_PERIOD_CYCLES - 1);
  localparam logic [31:0] RX_TO       = 32'(RX_TIMEOUT_CYCLES);
  localparam logic [31:0] BAD_READ    = 32'hDEAD_BEEF;

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  logic [31:0] r_kp       [NUM_MOTORS];
  logic [31:0] r_ki       [NUM_MOTORS];
  logic [31:0] r_kd       [NUM_MOTORS];
  logic [31:0] r_pwm_lim  [NUM_MOTORS];
  logic [31:0] r_int_lim  [NUM_MOTORS];
  logic [31:0] r_deadband [NUM_MOTORS];
  logic [2:0]  r_mode     [NUM_MOTORS];
  logic [31:0] r_sp       [NUM_MOTORS];
  logic [31:0] r_pos      [NUM_MOTORS];
  logic [31:0] r_vel      [NUM_MOTORS];
  logic [31:0] r_disp     [NUM_MOTORS];
  logic [15:0] r_cur      [NUM_MOTORS];
  logic [15:0] r_good     [NUM_MOTORS];
  logic        r_stream_en;
  logic [15:0] r_rx_err;

  logic [7:0]     w_bus_motor;
  logic [7:0]     w_bus_reg;
  logic [MIW-1:0] w_bus_idx;
  logic           w_bus_in_range;
  logic           w_bus_global;
  logic [31:0]    w_rdata;

  assign w_bus_motor    = address[15:8];
  assign w_bus_reg      = address[7:0];
  assign w_bus_idx      = w_bus_motor[MIW-1:0];
  assign w_bus_in_range = ({1'b0, w_bus_motor} < NM);
  assign w_bus_global   = (w_bus_motor == 8'hFF);

  // ---------------------------------------------------------------------------
  // Read path: the value is captured in the first read cycle, so a write in the
  // same cycle lands after the capture and the read sees the pre-write value.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rdata = BAD_READ;
    if (w_bus_global) begin
      case (w_bus_reg)
        8'h00:   w_rdata = {31'b0, r_stream_en};
        8'h01:   w_rdata = {16'b0, r_rx_err};
        default: w_rdata = BAD_READ;
      endcase
    end else if (w_bus_in_range) begin
      case (w_bus_reg)
        8'h01:   w_rdata = r_kp[w_bus_idx];
        8'h02:   w_rdata = r_ki[w_bus_idx];
        8'h03:   w_rdata = r_kd[w_bus_idx];
        8'h04:   w_rdata = r_pos[w_bus_idx];
        8'h05:   w_rdata = r_vel[w_bus_idx];
        8'h06:   w_rdata = r_disp[w_bus_idx];
        8'h07:   w_rdata = {{16{r_cur[w_bus_idx][15]}}, r_cur[w_bus_idx]};
        8'h08:   w_rdata = r_pwm_lim[w_bus_idx];
        8'h09:   w_rdata = r_int_lim[w_bus_idx];
        8'h0A:   w_rdata = r_deadband[w_bus_idx];
        8'h0B:   w_rdata = {29'b0, r_mode[w_bus_idx]};
        8'h0C:   w_rdata = r_sp[w_bus_idx];
        8'h0D:   w_rdata = {16'b0, r_good[w_bus_idx]};
        default: w_rdata = BAD_READ;
      endcase
    end
  end

  logic        r_rd_phase;
  logic [31:0] r_readdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_phase <= 1'b0;
      r_readdata <= 32'h0;
    end else if (read && !r_rd_phase) begin
      r_rd_phase <= 1'b1;
      r_readdata <= w_rdata;
    end else begin
      r_rd_phase <= 1'b0;
    end
  end

  assign waitrequest = read & ~r_rd_phase;
  assign readdata    = r_readdata;

  // ---------------------------------------------------------------------------
  // TX engine
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {TX_IDLE, TX_LATCH, TX_SEND} tx_state_t;

  tx_state_t      r_tx_state;
  tx_state_t      w_tx_next;
  logic [31:0]    r_period;
  logic           w_tick;
  logic [7:0]     r_tx_motor;
  logic [MIW-1:0] w_tx_idx;
  logic [2:0]     r_tx_byte;
  logic [2:0]     r_snap_mode;
  logic [31:0]    r_snap_sp;
  logic [7:0]     w_tx_csum;
  logic [7:0]     w_frame_byte;

  assign w_tick    = r_stream_en && (r_period == PERIOD_LAST);
  assign w_tx_idx  = r_tx_motor[MIW-1:0];
  assign w_tx_csum = r_tx_motor ^ {5'b0, r_snap_mode} ^ r_snap_sp[31:24] ^
                     r_snap_sp[23:16] ^ r_snap_sp[15:8] ^ r_snap_sp[7:0];

  always_comb begin
    w_frame_byte = 8'hA5;
    case (r_tx_byte)
      3'd0:    w_frame_byte = 8'hA5;
      3'd1:    w_frame_byte = r_tx_motor;
      3'd2:    w_frame_byte = {5'b0, r_snap_mode};
      3'd3:    w_frame_byte = r_snap_sp[31:24];
      3'd4:    w_frame_byte = r_snap_sp[23:16];
      3'd5:    w_frame_byte = r_snap_sp[15:8];
      3'd6:    w_frame_byte = r_snap_sp[7:0];
      default: w_frame_byte = w_tx_csum;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_tx_state <= TX_IDLE;
    else       r_tx_state <= w_tx_next;
  end

  // Ticks arriving outside IDLE are simply lost; the period counter keeps
  // running so frame starts stay on the period grid.
  always_comb begin
    w_tx_next = r_tx_state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (r_tx_state)
      TX_IDLE:  if (w_tick) w_tx_next = TX_LATCH;
      TX_LATCH: w_tx_next = TX_SEND;
      TX_SEND: begin
        tx_valid = 1'b1;
        tx_data  = w_frame_byte;
        if (tx_ready && (r_tx_byte == 3'd7)) w_tx_next = TX_IDLE;
      end
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_period    <= 32'h0;
      r_tx_motor  <= 8'h0;
      r_tx_byte   <= 3'd0;
      r_snap_mode <= 3'd0;
      r_snap_sp   <= 32'h0;
    end else begin
      if (!r_stream_en || w_tick) r_period <= 32'h0;
      else                        r_period <= r_period + 32'd1;

      if (r_tx_state == TX_LATCH) begin
        r_snap_mode <= r_mode[w_tx_idx];
        r_snap_sp   <= r_sp[w_tx_idx];
        r_tx_byte   <= 3'd0;
      end else if ((r_tx_state == TX_SEND) && tx_ready) begin
        if (r_tx_byte == 3'd7) begin
          r_tx_motor <= (r_tx_motor == LAST_MOTOR) ? 8'h0 : r_tx_motor + 8'd1;
        end else begin
          r_tx_byte <= r_tx_byte + 3'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RX engine
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_HUNT, RX_ID, RX_PAYLOAD, RX_CHECK} rx_state_t;

  rx_state_t      r_rx_state;
  rx_state_t      w_rx_next;
  logic [7:0]     r_rx_id;
  logic [MIW-1:0] w_rx_idx;
  logic [3:0]     r_rx_cnt;
  logic [111:0]   r_shadow;
  logic [7:0]     r_rx_xor;
  logic [7:0]     r_rx_csum;
  logic [31:0]    r_gap;
  logic           w_in_frame;
  logic           w_rx_timeout;
  logic           w_rx_commit;
  logic           w_rx_bad;

  assign w_rx_idx     = r_rx_id[MIW-1:0];
  assign w_in_frame   = (r_rx_state == RX_ID) || (r_rx_state == RX_PAYLOAD);
  assign w_rx_timeout = w_in_frame && !rx_valid && (r_gap == RX_TO);
  assign w_rx_commit  = (r_rx_state == RX_CHECK) && (r_rx_xor == r_rx_csum) &&
                        ({1'b0, r_rx_id} < NM);
  assign w_rx_bad     = ((r_rx_state == RX_CHECK) && !w_rx_commit) || w_rx_timeout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_rx_state <= RX_HUNT;
    else       r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_HUNT:    if (rx_valid && (rx_data == 8'h5A)) w_rx_next = RX_ID;
      RX_ID: begin
        if (w_rx_timeout)  w_rx_next = RX_HUNT;
        else if (rx_valid) w_rx_next = RX_PAYLOAD;
      end
      RX_PAYLOAD: begin
        if (w_rx_timeout)                        w_rx_next = RX_HUNT;
        else if (rx_valid && (r_rx_cnt == 4'd14)) w_rx_next = RX_CHECK;
      end
      default:    w_rx_next = RX_HUNT;
    endcase
  end

  // Payload bytes shift in MSB first; after 14 bytes the shadow holds
  // pos[111:80], vel[79:48], disp[47:16], current[15:0]. Byte 15 is the checksum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_id   <= 8'h0;
      r_rx_cnt  <= 4'd0;
      r_shadow  <= 112'h0;
      r_rx_xor  <= 8'h0;
      r_rx_csum <= 8'h0;
      r_gap     <= 32'h0;
    end else begin
      if (w_in_frame && !rx_valid) r_gap <= r_gap + 32'd1;
      else                         r_gap <= 32'h0;

      if ((r_rx_state == RX_ID) && rx_valid) begin
        r_rx_id  <= rx_data;
        r_rx_xor <= rx_data;
        r_rx_cnt <= 4'd0;
      end else if ((r_rx_state == RX_PAYLOAD) && rx_valid && !w_rx_timeout) begin
        if (r_rx_cnt == 4'd14) begin
          r_rx_csum <= rx_data;
        end else begin
          r_shadow <= {r_shadow[103:0], rx_data};
          r_rx_xor <= r_rx_xor ^ rx_data;
          r_rx_cnt <= r_rx_cnt + 4'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register writes and telemetry commit
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        r_kp[i]       <= 32'h0;
        r_ki[i]       <= 32'h0;
        r_kd[i]       <= 32'h0;
        r_pwm_lim[i]  <= 32'h0;
        r_int_lim[i]  <= 32'h0;
        r_deadband[i] <= 32'h0;
        r_mode[i]     <= 3'd0;
        r_sp[i]       <= 32'h0;
        r_pos[i]      <= 32'h0;
        r_vel[i]      <= 32'h0;
        r_disp[i]     <= 32'h0;
        r_cur[i]      <= 16'h0;
        r_good[i]     <= 16'h0;
      end
      r_stream_en <= 1'b0;
      r_rx_err    <= 16'h0;
    end else begin
      if (write && w_bus_in_range) begin
        case (w_bus_reg)
          8'h01:   r_kp[w_bus_idx]       <= writedata;
          8'h02:   r_ki[w_bus_idx]       <= writedata;
          8'h03:   r_kd[w_bus_idx]       <= writedata;
          8'h08:   r_pwm_lim[w_bus_idx]  <= writedata;
          8'h09:   r_int_lim[w_bus_idx]  <= writedata;
          8'h0A:   r_deadband[w_bus_idx] <= writedata;
          8'h0B:   r_mode[w_bus_idx]     <= writedata[2:0];
          8'h0C:   r_sp[w_bus_idx]       <= writedata;
          default: ;
        endcase
      end

      if (write && w_bus_global && (w_bus_reg == 8'h00)) r_stream_en <= writedata[0];

      // A bus clear wins over a simultaneous error event.
      if (write && w_bus_global && (w_bus_reg == 8'h01)) r_rx_err <= 16'h0;
      else if (w_rx_bad && (r_rx_err != 16'hFFFF))      r_rx_err <= r_rx_err + 16'd1;

      if (w_rx_commit) begin
        r_pos[w_rx_idx]  <= r_shadow[111:80];
        r_vel[w_rx_idx]  <= r_shadow[79:48];
        r_disp[w_rx_idx] <= r_shadow[47:16];
        r_cur[w_rx_idx]  <= r_shadow[15:0];
        r_good[w_rx_idx] <= r_good[w_rx_idx] + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_icebus_motor_bank.sv
// tb/tb_icebus_motor_bank.sv - self-checking bench for icebus_motor_bank

module tb_icebus_motor_bank;

  localparam int          NM  = 6;
  localparam int          UPD = 200;
  localparam int          TO  = 50;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = 16'h0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'h0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;

  icebus_motor_bank #(
    .NUM_MOTORS(NM),
    .UPDATE_PERIOD_CYCLES(UPD),
    .RX_TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .address(address), .write(write), .writedata(writedata),
    .read(read), .readdata(readdata), .waitrequest(waitrequest),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Accepted TX bytes and the cycle each was accepted in.
  logic [7:0] txq[$];
  int         txt[$];
  always @(negedge clock) begin
    if (tx_valid && tx_ready) begin
      txq.push_back(tx_data);
      txt.push_back(cyc);
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model: register contents by (motor, register number).
  logic [31:0] m_rw   [NM][16];
  logic [31:0] m_pos  [NM];
  logic [31:0] m_vel  [NM];
  logic [31:0] m_disp [NM];
  logic [15:0] m_cur  [NM];
  logic [15:0] m_good [NM];
  logic        m_en;
  int          m_err;

  function automatic bit is_rw(int r);
    return r inside {1, 2, 3, 8, 9, 10, 11, 12};
  endfunction

  function automatic logic [31:0] exp_read(logic [15:0] a);
    int m = int'(a[15:8]);
    int r = int'(a[7:0]);
    if (m == 255) begin
      if (r == 0) return {31'b0, m_en};
      if (r == 1) return 32'(m_err);
      return BAD;
    end
    if (m >= NM) return BAD;
    if (is_rw(r)) return m_rw[m][r];
    case (r)
      4:       return m_pos[m];
      5:       return m_vel[m];
      6:       return m_disp[m];
      7:       return 32'($signed(m_cur[m]));
      13:      return {16'b0, m_good[m]};
      default: return BAD;
    endcase
  endfunction

  task automatic m_write(logic [15:0] a, logic [31:0] d);
    int m = int'(a[15:8]);
    int r = int'(a[7:0]);
    if (m == 255) begin
      if (r == 0) m_en = d[0];
      if (r == 1) m_err = 0;
    end else if (m < NM && is_rw(r)) begin
      m_rw[m][r] = (r == 11) ? (d & 32'h7) : d;
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < NM; m++) begin
      for (int r = 0; r < 16; r++) m_rw[m][r] = 32'h0;
      m_pos[m] = 0; m_vel[m] = 0; m_disp[m] = 0; m_cur[m] = 0; m_good[m] = 0;
    end
    m_en = 1'b0;
    m_err = 0;
  endtask

  function automatic logic [63:0] exp_frame(int m);
    logic [7:0]  b [8];
    logic [31:0] sp = m_rw[m][12];
    logic [63:0] f;
    b[0] = 8'hA5; b[1] = 8'(m); b[2] = m_rw[m][11][7:0];
    b[3] = sp[31:24]; b[4] = sp[23:16]; b[5] = sp[15:8]; b[6] = sp[7:0];
    b[7] = 8'h0;
    for (int k = 1; k <= 6; k++) b[7] = b[7] ^ b[k];
    f = 64'h0;
    for (int k = 0; k < 8; k++) f = {f[55:0], b[k]};
    return f;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(logic [15:0] a, logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    step();
    write = 1'b0;
    m_write(a, d);
  endtask

  task automatic rd(logic [15:0] a, logic [31:0] exp, string tag);
    address = a; read = 1'b1;
    #1;
    chk({tag, "_wait1"}, 64'(waitrequest), 64'd1);
    step();
    chk({tag, "_wait2"}, 64'(waitrequest), 64'd0);
    chk(tag, 64'(readdata), 64'(exp));
    read = 1'b0;
    step();
  endtask

  task automatic send_byte(logic [7:0] b, int gap);
    rx_data = b; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    repeat (gap) step();
  endtask

  // Sends the first n bytes of a status frame; corrupt flips a checksum bit.
  task automatic send_frame(logic [7:0] id, logic [31:0] pos, logic [31:0] vel,
                            logic [31:0] disp, logic [15:0] cur, bit corrupt, int n);
    logic [7:0] b [17];
    b[0] = 8'h5A; b[1] = id;
    for (int k = 0; k < 4; k++) begin
      b[2 + k]  = pos[31 - 8*k -: 8];
      b[6 + k]  = vel[31 - 8*k -: 8];
      b[10 + k] = disp[31 - 8*k -: 8];
    end
    b[14] = cur[15:8]; b[15] = cur[7:0];
    b[16] = 8'h0;
    for (int k = 1; k <= 15; k++) b[16] = b[16] ^ b[k];
    if (corrupt) b[16] = b[16] ^ 8'h01;
    for (int k = 0; k < n; k++) send_byte(b[k], $urandom_range(1, 6));
  endtask

  task automatic rx_model(int id, logic [31:0] pos, logic [31:0] vel,
                          logic [31:0] disp, logic [15:0] cur, bit corrupt);
    if (!corrupt && id < NM) begin
      m_pos[id] = pos; m_vel[id] = vel; m_disp[id] = disp; m_cur[id] = cur;
      m_good[id] = m_good[id] + 16'd1;
    end else if (m_err < 16'hFFFF) begin
      m_err++;
    end
  endtask

  initial begin
    logic [15:0] a;
    logic [31:0] d, old, vel, disp;
    logic [63:0] got, expf;
    logic [8:0]  held;
    bit          stable, corrupt;
    int          m, r, id, nf;

    model_reset();
    repeat (3) step();
    chk("rst_readdata", 64'(readdata), 64'h0);
    chk("rst_waitrequest", 64'(waitrequest), 64'h0);
    chk("rst_tx_valid", 64'(tx_valid), 64'h0);
    chk("rst_tx_data", 64'(tx_data), 64'h0);
    reset = 1'b0;
    step();

    rd(16'h0201, 32'h0, "kp_m2_reset");
    rd(16'h0710, BAD, "motor7_out_of_range");
    rd(16'hFF01, 32'h0, "rx_err_reset");

    // Random register traffic, including RO/unmapped/out-of-range writes.
    for (int i = 0; i < 60; i++) begin
      m = $urandom_range(0, 8);
      if (m == 8) m = 255;
      r = $urandom_range(0, 15);
      if (m == 255 && r == 0) r = 2;
      a = {8'(m), 8'(r)};
      d = $urandom;
      if ($urandom_range(0, 1) == 1) wr(a, d);
      rd(a, exp_read(a), $sformatf("rand_%04h", a));
    end

    // Read and write in the same cycle: read returns the old value.
    a = 16'h0001;
    old = exp_read(a);
    d = $urandom;
    address = a; writedata = d; read = 1'b1; write = 1'b1;
    step();
    write = 1'b0;
    m_write(a, d);
    chk("rw_same_cycle_old", 64'(readdata), 64'(old));
    read = 1'b0;
    step();
    rd(a, d, "rw_same_cycle_new");

    // Command frame streaming.
    wr(16'h010C, 32'h12345678);
    wr(16'h010B, 32'h0);
    tx_ready = 1'b1;
    txq.delete(); txt.delete();
    wr(16'hFF00, 32'h1);
    nf = 7;
    for (int i = 0; i < nf * UPD + 400 && txq.size() < nf * 8; i++) step();
    chk("tx_byte_count", 64'(txq.size()), 64'(nf * 8));
    if (txq.size() >= nf * 8) begin
      for (int f = 0; f < nf; f++) begin
        got = 64'h0;
        for (int k = 0; k < 8; k++) got = {got[55:0], txq[f*8 + k]};
        chk($sformatf("tx_frame_%0d", f), got, exp_frame(f % NM));
        if (f > 0) chk($sformatf("tx_spacing_%0d", f), 64'(txt[f*8] - txt[(f-1)*8]), 64'(UPD));
      end
      chk("tx_m1_checksum", 64'(txq[15]), 64'h09);
    end

    // Stall mid-frame while sp is rewritten.
    tx_ready = 1'b0;
    txq.delete(); txt.delete();
    expf = exp_frame(nf % NM);
    for (int i = 0; i < UPD + 20 && !tx_valid; i++) step();
    chk("stall_frame_start", 64'(tx_valid), 64'd1);
    tx_ready = 1'b1;
    repeat (3) step();
    tx_ready = 1'b0;
    held = {tx_valid, tx_data};
    chk("stall_held_byte", 64'(held), {55'h0, 1'b1, expf[39:32]});
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) begin
        address = {8'(nf % NM), 8'h0C}; writedata = 32'hCAFEF00D; write = 1'b1;
      end
      if (i == 11) begin
        write = 1'b0;
        m_write({8'(nf % NM), 8'h0C}, 32'hCAFEF00D);
      end
      step();
      if ({tx_valid, tx_data} !== held) stable = 1'b0;
    end
    chk("stall_stable", 64'(stable), 64'd1);
    tx_ready = 1'b1;
    for (int i = 0; i < 50 && txq.size() < 8; i++) step();
    chk("stall_byte_count", 64'(txq.size()), 64'd8);
    if (txq.size() >= 8) begin
      got = 64'h0;
      for (int k = 0; k < 8; k++) got = {got[55:0], txq[k]};
      chk("stall_frame_old_sp", got, expf);
    end
    rd({8'(nf % NM), 8'h0C}, 32'hCAFEF00D, "stall_sp_new");

    // Asynchronous reset while the 4th byte is held.
    tx_ready = 1'b0;
    for (int i = 0; i < UPD + 20 && !tx_valid; i++) step();
    chk("rst_frame_start", 64'(tx_valid), 64'd1);
    tx_ready = 1'b1;
    repeat (3) step();
    tx_ready = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("async_rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("async_rst_tx_data", 64'(tx_data), 64'd0);
    model_reset();
    repeat (2) step();
    reset = 1'b0;
    txq.delete(); txt.delete();
    tx_ready = 1'b1;
    repeat (3 * UPD) step();
    chk("no_tx_after_reset", 64'(txq.size()), 64'd0);
    rd(16'h010C, 32'h0, "sp_after_reset");
    rd(16'hFF00, 32'h0, "stream_en_after_reset");

    // Status frames: leading garbage, then the directed id-3 frame.
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      if (d[7:0] == 8'h5A) d[7:0] = 8'h00;
      send_byte(d[7:0], 2);
    end
    vel = $urandom; disp = $urandom;
    send_frame(8'd3, 32'hFFFFFF00, vel, disp, 16'h8001, 1'b0, 17);
    rx_model(3, 32'hFFFFFF00, vel, disp, 16'h8001, 1'b0);
    repeat (3) step();
    rd(16'h0304, 32'hFFFFFF00, "rx_pos_m3");
    rd(16'h0305, vel, "rx_vel_m3");
    rd(16'h0307, 32'hFFFF8001, "rx_cur_m3");
    rd(16'h030D, 32'h1, "rx_good_m3");

    // Random frames: some corrupted, some with out-of-range ids.
    for (int i = 0; i < 6; i++) begin
      id = $urandom_range(0, 7);
      corrupt = ($urandom_range(0, 3) == 0);
      old = $urandom; vel = $urandom; disp = $urandom; d = $urandom;
      send_frame(8'(id), old, vel, disp, d[15:0], corrupt, 17);
      rx_model(id, old, vel, disp, d[15:0], corrupt);
      repeat (3) step();
      m = (id < NM) ? id : 0;
      for (int k = 4; k <= 7; k++) begin
        a = {8'(m), 8'(k)};
        rd(a, exp_read(a), $sformatf("rxr_%0d_%04h", i, a));
      end
      rd({8'(m), 8'h0D}, exp_read({8'(m), 8'h0D}), $sformatf("rxr_good_%0d", i));
      rd(16'hFF01, exp_read(16'hFF01), $sformatf("rxr_err_%0d", i));
    end

    // Bad checksum, then a frame truncated by a long gap.
    wr(16'hFF01, 32'h0);
    old = exp_read(16'h0204);
    send_frame(8'd2, 32'h11111111, 32'h2, 32'h3, 16'h4, 1'b1, 17);
    send_frame(8'd2, 32'h22222222, 32'h2, 32'h3, 16'h4, 1'b0, 8);
    repeat (2 * TO) step();
    rd(16'h0204, old, "rx_bad_pos_unchanged");
    rd(16'hFF01, 32'h2, "rx_err_two");
    wr(16'hFF01, 32'hFFFFFFFF);
    rd(16'hFF01, 32'h0, "rx_err_cleared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icebus_motor_bank.md
Name: icebus_motor_bank

Overview:
- Parametrised per-motor register bank on an Avalon-MM slave, plus a byte-stream protocol engine toward the iCE motor boards.
- Streams periodic command frames (control mode + setpoint) round-robin over all motors.
- Parses incoming status frames into read-only telemetry registers.
- Sits between the soft CPU's Avalon bus and an external UART byte core (the UART itself is not part of this block).

Parameters:
- NUM_MOTORS, 6, motor channels; valid range 1..255.
- UPDATE_PERIOD_CYCLES, 50000, clock cycles between command-frame starts (1 kHz at 50 MHz).
- RX_TIMEOUT_CYCLES, 5000, maximum inter-byte gap before the parser abandons a frame.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- address  in  16  [15:8] motor index (0xFF = global), [7:0] register
- write  in  1  Avalon write strobe
- writedata  in  32  write data
- read  in  1  Avalon read strobe
- readdata  out  32  read data
- waitrequest  out  1  Avalon wait
- tx_data  out  8  outgoing byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART accepts byte
- rx_data  in  8  incoming byte
- rx_valid  in  1  one-cycle strobe, rx_data valid

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clock.
- Register map, per motor m < NUM_MOTORS (RW unless noted):
  - 0x01 Kp, 0x02 Ki, 0x03 Kd
  - 0x04 position (RO), 0x05 velocity (RO), 0x06 displacement (RO), 0x07 current (RO, 16-bit sign-extended)
  - 0x08 PWMLimit, 0x09 IntegralLimit, 0x0A deadBand
  - 0x0B control_mode ([2:0] stored, upper bits read 0)
  - 0x0C sp
  - 0x0D good-frame count (RO, 16-bit, wraps)
- Global registers (motor 0xFF):
  - 0x00 control: bit0 stream_enable (RW).
  - 0x01 rx_error_count (RO, 16-bit, saturates at 0xFFFF); any write clears it.
- Reads: unmapped register, motor ≥ NUM_MOTORS (other than 0xFF), or RO-only addresses outside the map return 0xDEADBEEF.
- Writes: writes to RO, unmapped, or out-of-range addresses are ignored.
- Read timing: exactly one wait state.
  - waitrequest = 1 in the first cycle of read; readdata is valid and waitrequest = 0 in the second cycle.
  - waitrequest = 0 whenever read = 0.
  - Back-to-back reads each take 2 cycles.
- Write timing: zero wait states; the register updates on the clock edge where write = 1.
- Simultaneous read and write: the write takes effect, and the read returns the pre-write value.
- Reset values:
  - All RW motor registers 0, telemetry 0, counters 0, stream_enable 0.
  - readdata 0, waitrequest 0, tx_valid 0, tx_data 0.
- TX FSM states: IDLE, LATCH, SEND.
  - Period counter runs only while stream_enable = 1; it is cleared when stream_enable = 0.
  - When the counter reaches UPDATE_PERIOD_CYCLES-1: LATCH snapshots control_mode[m] and sp[m] for the current motor m, then SEND emits 8 bytes: 0xA5, m, control_mode, sp[31:24], sp[23:16], sp[15:8], sp[7:0], checksum.
  - checksum = XOR of bytes 1..6.
  - Each byte is held with tx_valid = 1 until the tx_ready handshake completes.
  - After the final byte: m advances (wraps NUM_MOTORS-1 → 0) and the FSM returns to IDLE.
  - A bus write to sp during SEND does not alter the frame in flight.
  - Clearing stream_enable mid-frame lets the current frame complete, then the FSM stays in IDLE.
  - If the period elapses while still in SEND, the tick is dropped; no queuing.
- RX FSM states: HUNT, ID, PAYLOAD, CHECK.
  - Frame is 17 bytes: 0x5A, id, pos(4), vel(4), disp(4), current(2), checksum; multi-byte fields are MSB first.
  - checksum = XOR of bytes 1..15.
  - HUNT discards every byte except 0x5A.
  - Payload is collected into a shadow buffer.
  - In CHECK, with checksum good and id < NUM_MOTORS: all four telemetry registers of motor id update in the same cycle, and that motor's good count increments.
  - Bad checksum or id ≥ NUM_MOTORS: rx_error_count increments; no telemetry changes.
  - Inter-byte gap > RX_TIMEOUT_CYCLES outside HUNT: return to HUNT and increment rx_error_count.
  - Bus reads of telemetry never observe a partial update.
- Asynchronous reset mid-frame: both FSMs go to IDLE/HUNT, tx_valid drops immediately, and the partial frame is discarded.

Test Plan:
- Reset, then read 0x0201 (Kp of motor 2) → waitrequest high for 1 cycle, readdata = 0; read 0x0710 → 0xDEADBEEF.
- Write 0x12345678 to 0x010C; write 1 to 0xFF00; tx_ready tied 1 → bytes A5 00 00 .. then, for motor 1: A5 01 00 12 34 56 78 checksum (0x01^0x00^0x12^0x34^0x56^0x78 = 0x09); frame starts spaced UPDATE_PERIOD_CYCLES apart; motor index wraps after NUM_MOTORS-1.
- tx_ready held 0 for 100 cycles mid-frame while sp is rewritten → tx_data/tx_valid stable, and the frame carries the old sp.
- Inject a valid status frame for id 3 with pos = 0xFFFFFF00 and current = 0x8001 → reading 0x0304 returns 0xFFFFFF00, 0x0307 returns 0xFFFF8001, and 0x030D returns 1.
- Inject a frame with a corrupted checksum, then a frame truncated by a gap > RX_TIMEOUT_CYCLES → telemetry unchanged, 0xFF01 reads 2; write 0xFF01 → reads 0.
- Assert reset during the 4th tx byte → tx_valid = 0 the same cycle; after release no bytes are sent until stream_enable is set again.
